branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 117 +++++++++++
 tb/tb_branch_resolve_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch resolution with control-delay stages, taken pulse and fetch/decode flush
module branch_resolve_unit #(
    parameter int DEPTH        = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int PC_WIDTH     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                stall,
    input  logic                branch,
    input  logic [2:0]          br_type,
    input  logic                zero,
    input  logic                neg,
    input  logic [PC_WIDTH-1:0] target,
    output logic                branch_reg,
    output logic                bz,
    output logic [PC_WIDTH-1:0] taken_pc,
    output logic                flush,
    output logic [15:0]         taken_cnt
);

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

    state_t                stage_dummy_unused;
    state_t                state_q;
    logic [DEPTH-1:0]      stage_br_q;
    logic [2:0]            stage_ty_q [DEPTH];
    logic [2:0]            cnt_q;
    logic                  bz_q;
    logic                  flush_q;
    logic [PC_WIDTH-1:0]   taken_pc_q;
    logic [15:0]           taken_cnt_q;

    logic                  advance;
    logic                  cond;
    logic                  take_d;
    logic [2:0]            final_ty;

    assign stage_dummy_unused = ST_IDLE;
    assign advance    = run & ~stall;
    assign branch_reg = stage_br_q[DEPTH-1];
    assign final_ty   = stage_ty_q[DEPTH-1];

    always_comb begin
        cond = 1'b0;
        case (final_ty)
            3'd0:    cond = zero;
            3'd1:    cond = ~zero;
            3'd2:    cond = neg;
            3'd3:    cond = ~neg;
            3'd4:    cond = ~neg & ~zero;
            3'd5:    cond = neg | zero;
            3'd6:    cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    // Branches are only resolved in IDLE; the flush shadow holds nothing but bubbles.
    assign take_d = (state_q == ST_IDLE) && branch_reg && cond;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            stage_br_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stage_ty_q[i] <= '0;
            end
            cnt_q       <= '0;
            bz_q        <= 1'b0;
            flush_q     <= 1'b0;
            taken_pc_q  <= '0;
            taken_cnt_q <= '0;
        end else begin
            // The taken pulse lasts one edge even when the pipeline is frozen.
            bz_q <= 1'b0;
            if (advance) begin
                if (take_d) begin
                    bz_q        <= 1'b1;
                    taken_pc_q  <= target;
                    taken_cnt_q <= taken_cnt_q + 16'd1;
                    flush_q     <= 1'b1;
                    cnt_q       <= 3'(FLUSH_CYCLES - 1);
                    stage_br_q  <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_ty_q[i] <= '0;
                    end
                    state_q     <= ST_FLUSH;
                end else begin
                    stage_br_q[0] <= flush_q ? 1'b0 : branch;
                    stage_ty_q[0] <= flush_q ? 3'd0 : br_type;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_br_q[i] <= stage_br_q[i-1];
                        stage_ty_q[i] <= stage_ty_q[i-1];
                    end
                    if (state_q == ST_FLUSH) begin
                        if (cnt_q == 3'd0) begin
                            flush_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 3'd1;
                        end
                    end
                end
            end
        end
    end

    assign bz        = bz_q;
    assign flush     = flush_q;
    assign taken_pc  = taken_pc_q;
    assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [2:0]  br_type = 3'd0;
    logic        zero = 1'b0;
    logic        neg = 1'b0;
    logic [31:0] target = 32'd0;

    logic        br1, bz1, fl1;
    logic [31:0] pc1;
    logic [15:0] cnt1;
    logic        br3, bz3, fl3;
    logic [31:0] pc3;
    logic [15:0] cnt3;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] ty;
        logic       z;
        logic       n;
        logic       take;
    } vec_t;

    typedef struct {
        logic        bz;
        logic        fl;
        logic [31:0] pc;
        logic [15:0] cnt;
    } exp_t;

    vec_t vecs [17];
    exp_t sbq [$];

    branch_resolve_unit #(.DEPTH(1), .FLUSH_CYCLES(2), .PC_WIDTH(32)) u1 (
        .clk(clk), .rst_n(rst_n), .run(run), .stall(stall), .branch(branch),
        .br_type(br_type), .zero(zero), .neg(neg), .target(target),
        .branch_reg(br1), .bz(bz1), .taken_pc(pc1), .flush(fl1), .taken_cnt(cnt1)
    );

    branch_resolve_unit #(.DEPTH(3), .FLUSH_CYCLES(2), .PC_WIDTH(32)) u3 (
        .clk(clk), .rst_n(rst_n), .run(run), .stall(stall), .branch(branch),
        .br_type(br_type), .zero(zero), .neg(neg), .target(target),
        .branch_reg(br3), .bz(bz3), .taken_pc(pc3), .flush(fl3), .taken_cnt(cnt3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        branch  = 1'b0;
        br_type = 3'd0;
        run     = 1'b1;
        stall   = 1'b0;
        rst_n   = 1'b0;
        #3;
        rst_n   = 1'b1;
        tick(1);
    endtask

    initial begin
        logic [31:0] m_pc;
        logic [15:0] m_cnt;
        exp_t        e;

        vecs[0]  = '{3'd0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{3'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'd1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'd1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{3'd2, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{3'd2, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd3, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{3'd3, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{3'd4, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{3'd4, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'd4, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{3'd5, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{3'd5, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{3'd5, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{3'd6, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{3'd7, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{3'd7, 1'b0, 1'b0, 1'b0};

        #1 rst_n = 1'b0;
        #3;
        chk("reset branch_reg", 32'(br1), 32'd0);
        chk("reset bz", 32'(bz1), 32'd0);
        chk("reset flush", 32'(fl1), 32'd0);
        chk("reset taken_pc", pc1, 32'd0);
        chk("reset taken_cnt", 32'(cnt1), 32'd0);
        chk("reset branch_reg d3", 32'(br3), 32'd0);
        do_reset();

        // Condition table on the DEPTH=1 unit.
        m_pc  = 32'd0;
        m_cnt = 16'd0;
        for (int i = 0; i < 17; i++) begin
            branch  = 1'b1;
            br_type = vecs[i].ty;
            zero    = vecs[i].z;
            neg     = vecs[i].n;
            target  = 32'h0040_0020 + 32'(i * 16);
            if (vecs[i].take) begin
                m_pc  = target;
                m_cnt = m_cnt + 16'd1;
            end
            sbq.push_back('{vecs[i].take, vecs[i].take, m_pc, m_cnt});
            tick(1);
            chk($sformatf("v%0d branch_reg", i), 32'(br1), 32'd1);
            branch = 1'b0;
            tick(1);
            e = sbq.pop_front();
            chk($sformatf("v%0d bz", i), 32'(bz1), 32'(e.bz));
            chk($sformatf("v%0d flush", i), 32'(fl1), 32'(e.fl));
            chk($sformatf("v%0d taken_pc", i), pc1, e.pc);
            chk($sformatf("v%0d taken_cnt", i), 32'(cnt1), 32'(e.cnt));
            tick(1);
            chk($sformatf("v%0d bz clear", i), 32'(bz1), 32'd0);
            chk($sformatf("v%0d flush hold", i), 32'(fl1), 32'(e.fl));
            tick(1);
            chk($sformatf("v%0d flush end", i), 32'(fl1), 32'd0);
            tick(1);
        end

        // DEPTH=3 delay, then with two stalled edges inside.
        do_reset();
        branch  = 1'b1;
        br_type = 3'd7;
        tick(1);
        chk("d3 e1", 32'(br3), 32'd0);
        branch = 1'b0;
        tick(1);
        chk("d3 e2", 32'(br3), 32'd0);
        tick(1);
        chk("d3 e3", 32'(br3), 32'd1);
        tick(1);
        chk("d3 e4", 32'(br3), 32'd0);
        branch = 1'b1;
        tick(1);
        branch = 1'b0;
        stall  = 1'b1;
        tick(2);
        chk("d3 stalled", 32'(br3), 32'd0);
        stall = 1'b0;
        tick(1);
        chk("d3 stall e4", 32'(br3), 32'd0);
        tick(1);
        chk("d3 stall e5", 32'(br3), 32'd1);

        // Taken JUMP with two BEQ in its shadow.
        do_reset();
        branch  = 1'b1;
        br_type = 3'd6;
        zero    = 1'b1;
        target  = 32'h0000_1000;
        tick(1);
        chk("jmp captured", 32'(br1), 32'd1);
        br_type = 3'd0;
        tick(1);
        chk("jmp bz", 32'(bz1), 32'd1);
        chk("jmp cnt", 32'(cnt1), 32'd1);
        chk("jmp shadow1 br", 32'(br1), 32'd0);
        tick(1);
        chk("jmp shadow2 br", 32'(br1), 32'd0);
        chk("jmp shadow2 bz", 32'(bz1), 32'd0);
        chk("jmp flush", 32'(fl1), 32'd1);
        branch = 1'b0;
        tick(1);
        chk("jmp post br", 32'(br1), 32'd0);
        chk("jmp post flush", 32'(fl1), 32'd0);
        tick(2);
        chk("jmp no extra bz", 32'(bz1), 32'd0);
        chk("jmp cnt final", 32'(cnt1), 32'd1);
        chk("jmp pc", pc1, 32'h0000_1000);

        // Asynchronous reset in the middle of the flush window.
        do_reset();
        branch  = 1'b1;
        br_type = 3'd6;
        tick(1);
        branch = 1'b0;
        tick(1);
        chk("rst pre flush", 32'(fl1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst async flush", 32'(fl1), 32'd0);
        chk("rst async bz", 32'(bz1), 32'd0);
        chk("rst async cnt", 32'(cnt1), 32'd0);
        chk("rst async pc", pc1, 32'd0);
        #1 rst_n = 1'b1;
        tick(1);
        chk("rst resume bz", 32'(bz1), 32'd0);
        chk("rst resume flush", 32'(fl1), 32'd0);

        // Counter wrap gated by run, and bz clearing while frozen.
        do_reset();
        force u1.taken_cnt_q = 16'hFFFF;
        #1;
        release u1.taken_cnt_q;
        chk("wrap preset", 32'(cnt1), 32'h0000_FFFF);
        branch  = 1'b1;
        br_type = 3'd6;
        target  = 32'h0000_2000;
        tick(1);
        chk("wrap pending", 32'(br1), 32'd1);
        branch = 1'b0;
        run    = 1'b0;
        tick(3);
        chk("wrap frozen bz", 32'(bz1), 32'd0);
        chk("wrap frozen cnt", 32'(cnt1), 32'h0000_FFFF);
        chk("wrap frozen br", 32'(br1), 32'd1);
        chk("wrap frozen flush", 32'(fl1), 32'd0);
        run = 1'b1;
        tick(1);
        chk("wrap bz", 32'(bz1), 32'd1);
        chk("wrap cnt", 32'(cnt1), 32'd0);
        chk("wrap pc", pc1, 32'h0000_2000);
        run = 1'b0;
        tick(1);
        chk("bz clear run0", 32'(bz1), 32'd0);
        chk("flush held run0", 32'(fl1), 32'd1);
        run = 1'b1;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
